// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with 8-word lines
// Optional hit/miss statistics counters enabled by ICACHE_STATS_EN.
module icache_dm #(
    parameter int NUM_LINES = 16,
    parameter int MISS_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        ready,
    output logic        stall,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_w0,
    input  logic [31:0] mem_w1,
    input  logic [31:0] mem_w2,
    input  logic [31:0] mem_w3,
    input  logic [31:0] mem_w4,
    input  logic [31:0] mem_w5,
    input  logic [31:0] mem_w6,
    input  logic [31:0] mem_w7
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = 27 - IDX_BITS;
    localparam int CNT_BITS = $clog2(MISS_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    logic [1:0]          state;
    logic [CNT_BITS-1:0] wait_cnt;
    logic [31:0]         miss_addr;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0] tag_mem  [NUM_LINES];
    logic [31:0]         data_mem [NUM_LINES][8];
    logic [31:0]         line_words [8];

    logic [IDX_BITS-1:0] pc_idx;
    logic [TAG_BITS-1:0] pc_tag;
    logic [2:0]          pc_off;
    logic [IDX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0] miss_tag;
    logic                hit;
    logic                unused_pc_bits;

    assign pc_off         = pc[4:2];
    assign pc_idx         = pc[4+IDX_BITS:5];
    assign pc_tag         = pc[31:5+IDX_BITS];
    assign miss_idx       = miss_addr[4+IDX_BITS:5];
    assign miss_tag       = miss_addr[31:5+IDX_BITS];
    assign unused_pc_bits = ^pc[1:0];

    assign hit = req & valid[pc_idx] & (tag_mem[pc_idx] == pc_tag);

    assign line_words[0] = mem_w0;
    assign line_words[1] = mem_w1;
    assign line_words[2] = mem_w2;
    assign line_words[3] = mem_w3;
    assign line_words[4] = mem_w4;
    assign line_words[5] = mem_w5;
    assign line_words[6] = mem_w6;
    assign line_words[7] = mem_w7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            miss_addr <= '0;
            valid     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && !hit) begin
                        miss_addr <= {pc[31:5], 5'b0};
                        wait_cnt  <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_BITS'(MISS_LAT - 1)) begin
                        state <= S_FILL;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_BITS'(1);
                    end
                end
                S_FILL: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                    if (!flush) begin
                        valid[miss_idx] <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
            // Flush is last so it overrides a same-edge fill of the valid bit.
            if (flush) begin
                valid <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state == S_FILL && !flush) begin
            tag_mem[miss_idx] <= miss_tag;
            for (int w = 0; w < 8; w++) begin
                data_mem[miss_idx][w] <= line_words[w];
            end
        end
    end

    always_comb begin
        instr    = '0;
        ready    = 1'b0;
        stall    = 1'b0;
        mem_addr = '0;
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    mem_addr = {pc[31:5], 5'b0};
                    if (hit) begin
                        ready = 1'b1;
                        instr = data_mem[pc_idx][pc_off];
                    end else if (req) begin
                        stall = 1'b1;
                    end
                end
                S_WAIT, S_FILL: begin
                    stall    = 1'b1;
                    mem_addr = miss_addr;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else if (req) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
module tb_icache_dm;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        ready;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_w0, mem_w1, mem_w2, mem_w3, mem_w4, mem_w5, mem_w6, mem_w7;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks;
    int failures;

    icache_dm #(.NUM_LINES(16), .MISS_LAT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .pc       (pc),
        .flush    (flush),
        .instr    (instr),
        .ready    (ready),
        .stall    (stall),
        .mem_addr (mem_addr),
        .mem_w0   (mem_w0),
        .mem_w1   (mem_w1),
        .mem_w2   (mem_w2),
        .mem_w3   (mem_w3),
        .mem_w4   (mem_w4),
        .mem_w5   (mem_w5),
        .mem_w6   (mem_w6),
        .mem_w7   (mem_w7)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line at 0x100 holds 0xA000_0000+i; every other line holds 0x1000_0000+addr+4*i.
    function automatic logic [31:0] mword(input logic [31:0] a, input int i);
        if (a == 32'h100) return 32'hA000_0000 + 32'(i);
        return 32'h1000_0000 + a + 32'(4 * i);
    endfunction

    always_comb begin
        mem_w0 = mword(mem_addr, 0);
        mem_w1 = mword(mem_addr, 1);
        mem_w2 = mword(mem_addr, 2);
        mem_w3 = mword(mem_addr, 3);
        mem_w4 = mword(mem_addr, 4);
        mem_w5 = mword(mem_addr, 5);
        mem_w6 = mword(mem_addr, 6);
        mem_w7 = mword(mem_addr, 7);
    end

    // Issue a request and run it to the first ready cycle, counting stall cycles.
    task automatic run_req(input string name, input logic [31:0] addr,
                           input int exp_stalls, input logic [31:0] exp_instr);
        int n;
        bit addr_ok;
        n = 0;
        addr_ok = 1'b1;
        @(negedge clk);
        req = 1'b1;
        pc  = addr;
        #1;
        while (stall && n < 40) begin
            if (mem_addr !== {addr[31:5], 5'b0}) addr_ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n !== exp_stalls) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, n, exp_stalls);
        end
        checks++;
        if (!addr_ok) begin
            failures++;
            $display("FAIL %s mem_addr not held at 0x%08h during stall", name, {addr[31:5], 5'b0});
        end
        checks++;
        if (ready !== 1'b1 || instr !== exp_instr) begin
            failures++;
            $display("FAIL %s result got ready=%0b instr=0x%08h exp ready=1 instr=0x%08h",
                     name, ready, instr, exp_instr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b1;
        pc    = 32'h100;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (instr !== 32'h0 || ready !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got instr=0x%08h ready=%0b stall=%0b mem_addr=0x%08h exp all 0",
                     instr, ready, stall, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 1'b0;
    endtask

    task automatic test_cold_miss();
        run_req("cold_miss", 32'h100, 6, 32'hA000_0000);
    endtask

    task automatic test_hit();
        @(negedge clk);
        req = 1'b1;
        pc  = 32'h10C;
        #1;
        checks++;
        if (ready !== 1'b1 || stall !== 1'b0 || instr !== 32'hA000_0003) begin
            failures++;
            $display("FAIL hit_10c got ready=%0b stall=%0b instr=0x%08h exp ready=1 stall=0 instr=0xa0000003",
                     ready, stall, instr);
        end
        @(negedge clk);
        pc = 32'h11C;
        #1;
        checks++;
        if (ready !== 1'b1 || stall !== 1'b0 || instr !== 32'hA000_0007) begin
            failures++;
            $display("FAIL hit_11c got ready=%0b stall=%0b instr=0x%08h exp ready=1 stall=0 instr=0xa0000007",
                     ready, stall, instr);
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || stall !== 1'b0 || instr !== 32'h0 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL idle_noreq got ready=%0b stall=%0b instr=0x%08h mem_addr=0x%08h exp 0/0/0/0x100",
                     ready, stall, instr, mem_addr);
        end
    endtask

    task automatic test_conflict();
        run_req("conflict_300", 32'h300, 6, 32'h1000_0300);
        run_req("conflict_304", 32'h304, 0, 32'h1000_0304);
        run_req("refetch_100", 32'h100, 6, 32'hA000_0000);
    endtask

    task automatic test_flush();
        @(negedge clk);
        req = 1'b1;
        pc  = 32'h200;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_detect stall got=%0b exp=1", stall);
        end
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req   = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || ready !== 1'b0 || mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL flush_abort got stall=%0b ready=%0b mem_addr=0x%08h exp 0/0/0x200",
                     stall, ready, mem_addr);
        end
        run_req("post_flush_100", 32'h100, 6, 32'hA000_0000);
        run_req("post_flush_200", 32'h200, 6, 32'h1000_0200);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        req = 1'b1;
        pc  = 32'h300;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL fill_cycle got stall=%0b mem_addr=0x%08h exp 1/0x300", stall, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr !== 32'h0 || ready !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_fill got instr=0x%08h ready=%0b stall=%0b mem_addr=0x%08h exp all 0",
                     instr, ready, stall, mem_addr);
        end
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
        run_req("post_reset_100", 32'h100, 6, 32'hA000_0000);
        run_req("post_reset_200", 32'h200, 6, 32'h1000_0200);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_req("stats_cold", 32'h100, 6, 32'hA000_0000);
        run_req("stats_hit1", 32'h104, 0, 32'hA000_0001);
        run_req("stats_hit2", 32'h108, 0, 32'hA000_0002);
        run_req("stats_hit3", 32'h10C, 0, 32'hA000_0003);
        run_req("stats_conflict", 32'h300, 6, 32'h1000_0300);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (hit_cnt !== 32'd5 || miss_cnt !== 32'd2) begin
            failures++;
            $display("FAIL stats got hit_cnt=%0d miss_cnt=%0d exp 5/2", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        pc       = 32'h0;
        flush    = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_reset_mid_fill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
